mux_n_to_1_reg: RTL and testbench
=================================

MUX_N_TO_1_REG -- requirements
Module: mux_n_to_1_reg

Interface
REQ-001 Parameter WIDTH, default 16, bit width of each data channel.
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter SELW, default 2, select/index width; SHALL satisfy 2**SELW >= N.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 mode  input  1  channel selection: 0 = fixed select, 1 = round-robin.
REQ-007 sel  input  SELW  channel index used when mode=0.
REQ-008 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  N  per-channel data-valid.
REQ-010 in_ready  output  N  one-hot grant, combinational; channel i transfers when in_valid[i] and in_ready[i].
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_idx  output  SELW  registered index of the channel that produced out_data.
REQ-013 out_valid  output  1  out_data/out_idx valid.
REQ-014 out_ready  input  1  downstream accepts out_data when out_valid and out_ready.

Function
REQ-015 load = !out_valid || out_ready; no grant SHALL be issued when load=0.
REQ-016 in_ready SHALL have at most one bit set, and only for a channel with in_valid high.
REQ-017 Mode 0: when load=1, sel<N and in_valid[sel]=1, in_ready[sel]=1; otherwise in_ready=0.
REQ-018 Mode 0 with sel>=N: no grant; treated as no request.
REQ-019 Mode 1: when load=1, grant the first channel with in_valid set, searching upward from rr_ptr modulo N.
REQ-020 rr_ptr is an internal SELW-bit register; after a mode-1 grant to channel g, rr_ptr <= g+1, or 0 when g=N-1.
REQ-021 rr_ptr SHALL hold when no grant occurs or mode=0.
REQ-022 On a grant to channel g: out_data <= in_data[g], out_idx <= g, out_valid <= 1 on the next edge; latency exactly 1 cycle.
REQ-023 load=1 with no grant: out_valid <= 0; out_data and out_idx hold.
REQ-024 load=0 (stall): out_data, out_idx, out_valid SHALL hold unchanged regardless of in_data, sel or mode changes.
REQ-025 Simultaneous accept and grant (out_valid=1, out_ready=1, grant): new data loads the same edge; full throughput of 1 transfer per cycle.
REQ-026 mode or sel change SHALL affect only the combinational grant of the current cycle; no internal state other than rr_ptr depends on them.
REQ-027 in_valid dropping while load=0 SHALL NOT alter outputs; no data is lost because no grant was given.

Reset
REQ-028 When rst_n=0 at a rising edge: out_valid <= 0, out_data <= 0, out_idx <= 0, rr_ptr <= 0.
REQ-029 While rst_n=0, in_ready SHALL be 0.
REQ-030 Reset asserted mid-stall SHALL discard the held output; after release, first grant in mode 1 starts from channel 0.

Verification
REQ-031 Mode 0, sel=2, in_valid=4'b0100, data2=16'hBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=16'hBEEF, out_idx=2, out_valid=1.
REQ-032 Mode 1, in_valid=4'b1111 held, out_ready=1, after reset -> grants 0,1,2,3,0 on consecutive cycles; out_idx follows one cycle later.
REQ-033 Mode 1, in_valid=4'b1001, rr_ptr=3 -> grant 3, then 0, then 3 (wrap-around).
REQ-034 out_valid=1, out_ready=0 for 3 cycles with changing in_data/in_valid -> in_ready=0, outputs constant; out_ready=1 -> handoff and new load same edge.
REQ-035 Mode 0, sel=3, in_valid=4'b0111 -> in_ready=0, out_valid=0 next cycle, out_data unchanged.
REQ-036 rst_n=0 for one cycle during stall with out_data=16'h1234 -> out_valid=0, out_data=0, out_idx=0; next mode-1 grant goes to lowest valid channel from 0.

Source files
------------

// File: rtl/mux_n_to_1_reg.sv
// rtl/mux_n_to_1_reg.sv - N-to-1 registered channel mux with fixed-select or round-robin grant
module mux_n_to_1_reg #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_idx,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             load;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [SELW:0]    cand;
    logic [WIDTH-1:0] gnt_data;

    assign load = !out_valid_q || out_ready;

    // Grant search; the extra bit on cand keeps rr_ptr + k from overflowing before the modulo fold.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (rst_n && load) begin
            if (!mode) begin
                if (({1'b0, sel} < (SELW+1)'(N)) && in_valid[sel]) begin
                    gnt_any = 1'b1;
                    gnt_idx = sel;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    cand = {1'b0, rr_ptr_q} + (SELW+1)'(k);
                    if (cand >= (SELW+1)'(N)) begin
                        cand = cand - (SELW+1)'(N);
                    end
                    if (!gnt_any && in_valid[cand[SELW-1:0]]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand[SELW-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (gnt_any) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (SELW'(i) == gnt_idx) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                out_data_d = gnt_data;
                out_idx_d  = gnt_idx;
                if (mode) begin
                    rr_ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// tb/tb_mux_n_to_1_reg.sv - directed-vector bench for mux_n_to_1_reg
module tb_mux_n_to_1_reg;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic               clk;
    logic               rst_n;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_idx;
    logic               out_valid;
    logic               out_ready;

    int errors = 0;
    int checks = 0;

    mux_n_to_1_reg #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [WIDTH-1:0] v);
        in_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_post();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] d, input logic [1:0] idx, input logic v);
        check_eq({tag, ".data"}, 32'(out_data), 32'(d));
        check_eq({tag, ".idx"}, 32'(out_idx), 32'(idx));
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(v));
    endtask

    int exp_g [5] = '{0, 1, 2, 3, 0};
    int exp_w [3] = '{3, 0, 3};

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_data   = '0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 16'h1111 * (i + 1));

        // reset: no grant while rst_n low, outputs cleared
        to_neg();
        check_eq("rst.in_ready", 32'(in_ready), 32'h0);
        to_post();
        to_neg();
        check_eq("rst.in_ready2", 32'(in_ready), 32'h0);
        check_out("rst", 16'h0000, 2'd0, 1'b0);
        to_post();
        rst_n    = 1'b1;
        in_valid = '0;

        // fixed select, channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; set_ch(2, 16'hBEEF);
        to_neg();
        check_eq("m0.in_ready", 32'(in_ready), 32'h4);
        to_post();
        check_out("m0", 16'hBEEF, 2'd2, 1'b1);

        // fixed select on a non-valid channel: no grant, data holds
        sel = 2'd3; in_valid = 4'b0111;
        to_neg();
        check_eq("m0nv.in_ready", 32'(in_ready), 32'h0);
        to_post();
        check_out("m0nv", 16'hBEEF, 2'd2, 1'b0);

        // round-robin, all valid, full throughput from rr_ptr=0
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_ch(i, 16'hA000 + 16'(i));
        for (int c = 0; c < 5; c++) begin
            to_neg();
            check_eq($sformatf("rr%0d.in_ready", c), 32'(in_ready), 32'(1 << exp_g[c]));
            to_post();
            check_out($sformatf("rr%0d", c), 16'hA000 + 16'(exp_g[c]), 2'(exp_g[c]), 1'b1);
        end

        // rr_ptr now 1: grant channel 2 moves it to 3, then wrap over 4'b1001
        in_valid = 4'b0100;
        to_neg();
        check_eq("rr_pre.in_ready", 32'(in_ready), 32'h4);
        to_post();
        in_valid = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            to_neg();
            check_eq($sformatf("wrap%0d.in_ready", c), 32'(in_ready), 32'(1 << exp_w[c]));
            to_post();
            check_out($sformatf("wrap%0d", c), 16'hA000 + 16'(exp_w[c]), 2'(exp_w[c]), 1'b1);
        end

        // stall: inputs churn, nothing granted, outputs frozen
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 4'(4'b0101 << c);
            mode     = c[0];
            sel      = 2'(c);
            set_ch(c, 16'h7000 + 16'(c));
            to_neg();
            check_eq($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'h0);
            to_post();
            check_out($sformatf("stall%0d", c), 16'hA003, 2'd3, 1'b1);
        end

        // release: handoff and new load on the same edge; rr_ptr is 0
        out_ready = 1'b1; mode = 1'b1; in_valid = 4'b0010; set_ch(1, 16'h5555);
        to_neg();
        check_eq("rel.in_ready", 32'(in_ready), 32'h2);
        to_post();
        check_out("rel", 16'h5555, 2'd1, 1'b1);

        // accept with nothing offered: valid drops, data holds
        in_valid = '0;
        to_neg();
        check_eq("idle.in_ready", 32'(in_ready), 32'h0);
        to_post();
        check_out("idle", 16'h5555, 2'd1, 1'b0);

        // load 0x1234, stall, then reset mid-stall (rr_ptr is 2 before reset)
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; set_ch(0, 16'h1234);
        to_post();
        check_out("ld1234", 16'h1234, 2'd0, 1'b1);
        out_ready = 1'b0; in_valid = 4'b1111;
        to_post();
        check_out("hold1234", 16'h1234, 2'd0, 1'b1);
        rst_n = 1'b0;
        to_neg();
        check_eq("mrst.in_ready", 32'(in_ready), 32'h0);
        to_post();
        check_out("mrst", 16'h0000, 2'd0, 1'b0);
        rst_n = 1'b1; mode = 1'b1; in_valid = 4'b1110;
        for (int i = 0; i < N; i++) set_ch(i, 16'hC000 + 16'(i));
        to_neg();
        check_eq("post_rst.in_ready", 32'(in_ready), 32'h2);
        to_post();
        check_out("post_rst", 16'hC001, 2'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
